// File: rtl/pilot_insert_sched.sv
// Pilot insertion scheduler: emits one OFDM symbol at a time, interleaving
// programmed pilot words with data subcarriers taken from the input stream.
module pilot_insert_sched #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cfg_enable,
    input  logic [LEN_W-1:0]  cfg_sym_len,
    input  logic [LEN_W-1:0]  cfg_pilot_offset,
    input  logic [LEN_W-1:0]  cfg_pilot_spacing,
    input  logic [DATA_W-1:0] cfg_pilot_value,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic [15:0]       sym_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t state, stateNext;

    logic [LEN_W-1:0]  symLen;
    logic [LEN_W-1:0]  spacing;
    logic [DATA_W-1:0] pilotVal;
    logic [LEN_W-1:0]  pc;
    logic [LEN_W-1:0]  k;

    logic adv;
    logic isPilot;
    logic produce;
    logic lastSlot;

    always_comb begin
        // The output register may take a new slot whenever it is empty or being drained.
        adv           = !m_axis_tvalid || m_axis_tready;
        isPilot       = (spacing != '0) && (pc == '0);
        lastSlot      = (k == symLen);
        s_axis_tready = (state == RUN) && !isPilot && adv;
        produce       = (state == RUN) && adv && (isPilot || s_axis_tvalid);
        stateNext     = state;
        case (state)
            IDLE: if (cfg_enable) stateNext = LOAD;
            LOAD: stateNext = RUN;
            RUN: begin
                if (produce && lastSlot) begin
                    stateNext = cfg_enable ? LOAD : IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            symLen   <= '0;
            spacing  <= '0;
            pilotVal <= '0;
        end else if (state == LOAD) begin
            symLen   <= cfg_sym_len;
            spacing  <= cfg_pilot_spacing;
            pilotVal <= cfg_pilot_value;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            k             <= '0;
            pc            <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (state == LOAD) begin
                k  <= '0;
                pc <= cfg_pilot_offset;
            end
            if (produce) begin
                m_axis_tdata  <= isPilot ? pilotVal : s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= lastSlot;
                k             <= k + 1'b1;
                if (isPilot) begin
                    pc <= spacing - 1'b1;
                end else if (pc != '0) begin
                    pc <= pc - 1'b1;
                end
            end else if (adv) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sym_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            sym_count <= sym_count + 16'd1;
        end
    end

    assign busy = (state != IDLE) || m_axis_tvalid;

endmodule

// File: tb/tb_pilot_insert_sched.sv
// Directed bench for pilot_insert_sched: a slot-list model predicts every output
// word, and a negedge monitor scores handshakes, hold stability and sym_count.
module tb_pilot_insert_sched;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam logic [DATA_W-1:0] PA = 32'hA5A5A5A5;
    localparam logic [DATA_W-1:0] PB = 32'h5A5A5A5A;

    logic              tb_ACLK = 1'b0;
    logic              tb_ARESETN;
    logic              cfgEnable;
    logic [LEN_W-1:0]  cfgSymLen, cfgOffset, cfgSpacing;
    logic [DATA_W-1:0] cfgPilot;
    logic [DATA_W-1:0] sTdata;
    logic              sTvalid, sTready;
    logic [DATA_W-1:0] mTdata;
    logic              mTvalid, mTready, mTlast;
    logic              busy;
    logic [15:0]       symCount;

    pilot_insert_sched #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .cfg_enable(cfgEnable),
        .cfg_sym_len(cfgSymLen), .cfg_pilot_offset(cfgOffset),
        .cfg_pilot_spacing(cfgSpacing), .cfg_pilot_value(cfgPilot),
        .s_axis_tdata(sTdata), .s_axis_tvalid(sTvalid), .s_axis_tready(sTready),
        .m_axis_tdata(mTdata), .m_axis_tvalid(mTvalid), .m_axis_tready(mTready),
        .m_axis_tlast(mTlast), .busy(busy), .sym_count(symCount)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int errors = 0;
    int checks = 0;
    logic [DATA_W:0]   expQ[$];
    logic [DATA_W-1:0] got[$];
    int hsCycle[$];
    int hsCount = 0;
    int cyc = 0;
    int stallCount = 0;
    logic [15:0]       modelSym = '0;
    logic [DATA_W-1:0] modelData = 1;
    logic [DATA_W-1:0] inData = 1;
    int accepted = 0;
    int srcLimit = 1 << 30;
    bit readyMode = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Slot j is a pilot when it sits at offset + n*spacing; data slots consume inputs in order.
    function automatic void expectSymbol(int len, int off, int sp, logic [DATA_W-1:0] pv);
        bit pil;
        for (int j = 0; j <= len; j++) begin
            pil = (sp != 0) && (j >= off) && (((j - off) % sp) == 0);
            if (pil) begin
                expQ.push_back({(j == len), pv});
            end else begin
                expQ.push_back({(j == len), modelData});
                modelData++;
            end
        end
    endfunction

    always @(posedge tb_ACLK) cyc++;

    initial begin
        bit hs;
        sTvalid = 1'b0;
        sTdata  = '0;
        mTready = 1'b1;
        forever begin
            @(negedge tb_ACLK);
            hs = sTvalid && sTready && tb_ARESETN;
            @(posedge tb_ACLK);
            #1;
            if (hs) begin
                inData++;
                accepted++;
            end
            sTdata  = inData;
            sTvalid = (accepted < srcLimit);
            mTready = readyMode ? ~mTready : 1'b1;
        end
    end

    logic              stallValid = 1'b0;
    logic [DATA_W-1:0] stallData;
    logic              stallLast;

    always @(negedge tb_ACLK) begin
        logic [DATA_W:0] e;
        if (!tb_ARESETN) begin
            stallValid = 1'b0;
        end else begin
            check("sym_count", symCount, modelSym);
            if (stallValid) begin
                check("hold", {mTvalid, mTlast, mTdata}, {1'b1, stallLast, stallData});
            end
            if (mTvalid && mTready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%0h required=none", mTdata);
                end else begin
                    e = expQ.pop_front();
                    check($sformatf("word%0d", hsCount), {mTlast, mTdata}, e);
                end
                got.push_back(mTdata);
                hsCycle.push_back(cyc);
                hsCount++;
                if (mTlast) modelSym++;
            end
            stallValid = mTvalid && !mTready;
            stallData  = mTdata;
            stallLast  = mTlast;
            if (stallValid) stallCount++;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge tb_ACLK);
            #1;
        end
    endtask

    task automatic waitHs(int n);
        int t = 0;
        while (hsCount < n && t < 400) begin
            @(negedge tb_ACLK);
            #1;
            t++;
        end
        check("wait_handshakes", (hsCount >= n), 1);
        tick(1);
    endtask

    task automatic waitBusy();
        int t = 0;
        while (!busy && t < 50) begin
            @(negedge tb_ACLK);
            #1;
            t++;
        end
        check("busy_rise", busy, 1);
        tick(1);
    endtask

    task automatic waitIdle();
        int t = 0;
        while ((busy || expQ.size() != 0) && t < 1000) begin
            @(negedge tb_ACLK);
            #1;
            t++;
        end
        check("idle", {busy, (expQ.size() == 0)}, 2'b01);
        tick(1);
    endtask

    task automatic setCfg(int len, int off, int sp, logic [DATA_W-1:0] pv);
        cfgSymLen  = LEN_W'(len);
        cfgOffset  = LEN_W'(off);
        cfgSpacing = LEN_W'(sp);
        cfgPilot   = pv;
    endtask

    task automatic startOne();
        cfgEnable = 1'b1;
        waitBusy();
        cfgEnable = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] basicExp [8];
        logic [DATA_W-1:0] base0;
        int base;
        int acc0;
        basicExp = '{32'h1, PA, 32'h2, 32'h3, PA, 32'h4, 32'h5, PA};

        tb_ARESETN = 1'b0;
        cfgEnable  = 1'b0;
        setCfg(0, 0, 0, '0);
        tick(3);
        check("rst_outputs", {sTready, mTvalid, mTlast, busy, symCount, mTdata}, '0);
        tb_ARESETN = 1'b1;
        tick(2);

        // Basic symbol twice back-to-back
        setCfg(7, 1, 3, PA);
        got.delete();
        hsCycle.delete();
        expectSymbol(7, 1, 3, PA);
        expectSymbol(7, 1, 3, PA);
        cfgEnable = 1'b1;
        waitHs(9);
        cfgEnable = 1'b0;
        waitIdle();
        for (int i = 0; i < 8; i++) check($sformatf("basic_word%0d", i), got[i], basicExp[i]);
        check("basic_sym_count", symCount, 2);
        check("basic_rate", hsCycle[7] - hsCycle[0], 7);
        check("basic_bubble", hsCycle[8] - hsCycle[7], 2);

        // No pilots
        setCfg(3, 0, 0, 32'hDEADBEEF);
        hsCycle.delete();
        expectSymbol(3, 0, 0, 32'hDEADBEEF);
        startOne();
        waitIdle();
        check("nopilot_rate", hsCycle[3] - hsCycle[0], 3);

        // Backpressure
        setCfg(7, 1, 3, PA);
        stallCount = 0;
        readyMode = 1'b1;
        expectSymbol(7, 1, 3, PA);
        startOne();
        waitIdle();
        readyMode = 1'b0;
        tick(2);
        check("bp_stalls_seen", (stallCount > 0), 1);

        // Input starvation after first data word
        base = hsCount;
        srcLimit = accepted + 1;
        expectSymbol(7, 1, 3, PA);
        startOne();
        tick(12);
        check("starve_count", hsCount - base, 2);
        check("starve_valid", mTvalid, 0);
        srcLimit = 1 << 30;
        waitIdle();

        // Pilot value change mid-symbol, then enable dropped mid-symbol
        base = hsCount;
        got.delete();
        expectSymbol(7, 1, 3, PA);
        expectSymbol(7, 1, 3, PB);
        cfgEnable = 1'b1;
        waitHs(base + 3);
        cfgPilot = PB;
        waitHs(base + 10);
        cfgEnable = 1'b0;
        waitIdle();
        check("cfg_old_last_pilot", got[7], PA);
        check("cfg_new_first_pilot", got[9], PB);
        base = hsCount;
        tick(6);
        check("stays_idle", {busy, 32'(hsCount - base)}, '0);

        // Offset beyond sym_len
        expectSymbol(3, 5, 2, PA);
        setCfg(3, 5, 2, PA);
        startOne();
        waitIdle();

        // spacing = 1
        got.delete();
        base0 = modelData;
        setCfg(4, 2, 1, PA);
        expectSymbol(4, 2, 1, PA);
        startOne();
        waitIdle();
        check("sp1_data1", got[1], base0 + 1);
        check("sp1_pilot2", got[2], PA);
        check("sp1_pilot4", got[4], PA);

        // sym_len = 0, three single-slot symbols
        hsCycle.delete();
        setCfg(0, 0, 0, PA);
        expectSymbol(0, 0, 0, PA);
        expectSymbol(0, 0, 0, PA);
        expectSymbol(0, 0, 0, PA);
        base = hsCount;
        cfgEnable = 1'b1;
        waitHs(base + 2);
        cfgEnable = 1'b0;
        waitIdle();
        check("len0_spacing", hsCycle[2] - hsCycle[1], 2);

        // Pilot-only symbol consumes no input
        acc0 = accepted;
        got.delete();
        setCfg(0, 0, 1, PB);
        expectSymbol(0, 0, 1, PB);
        startOne();
        waitIdle();
        check("pilot_only_word", got[0], PB);
        check("pilot_only_noinput", accepted - acc0, 0);

        // Reset at slot 4
        setCfg(7, 1, 3, PA);
        base = hsCount;
        expectSymbol(7, 1, 3, PA);
        cfgEnable = 1'b1;
        waitHs(base + 4);
        tb_ARESETN = 1'b0;
        #1;
        check("rst_mid_outputs", {sTready, mTvalid, mTlast, busy, symCount, mTdata}, '0);
        expQ.delete();
        modelSym = '0;
        tick(3);
        modelData = inData;
        base0 = inData;
        got.delete();
        expectSymbol(7, 1, 3, PA);
        check("rst_sym_count_pre", symCount, 0);
        tb_ARESETN = 1'b1;
        waitBusy();
        cfgEnable = 1'b0;
        waitIdle();
        check("rst_fresh_slot0", got[0], base0);
        check("rst_fresh_slot1", got[1], PA);
        check("rst_sym_count_post", symCount, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
